matrix_operand_loader: RTL and testbench

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

---
 rtl/matrix_operand_loader_if.sv | 48 ++++
 rtl/matrix_operand_loader.sv | 145 ++++++++++++++
 tb/tb_matrix_operand_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_loader_if.sv
// Handshake and data bundle between an element source, the operand loader
// and the downstream MAC unit that consumes packed matrix pairs.
interface matrix_operand_loader_if #(
    parameter int M_SIZE     = 4,
    parameter int VAR_WIDTH  = 8,
    parameter int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH
);

    // element stream into the loader
    logic                  in_valid;
    logic                  in_ready;
    logic [VAR_WIDTH-1:0]  in_a;
    logic [VAR_WIDTH-1:0]  in_b;
    logic                  in_last;

    // packed matrix pair towards the MAC unit
    logic [DATA_WIDTH-1:0] matrixA;
    logic [DATA_WIDTH-1:0] matrixB;
    logic                  out_valid;
    logic                  out_ready;

    // source of elements and sink of matrices
    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_last,
        output out_ready,
        input  in_ready,
        input  matrixA,
        input  matrixB,
        input  out_valid
    );

    // the loader itself
    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_last,
        input  out_ready,
        output in_ready,
        output matrixA,
        output matrixB,
        output out_valid
    );

endinterface

// File: rtl/matrix_operand_loader.sv
// Collects a row-major stream of element pairs into two packed square
// matrices and presents them to a MAC unit with a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FILL     | accepting element pairs while enable=1, idx = next element
// PRESENT  | packed pair complete, out_valid=1, waiting for out_ready
//
// A frame whose in_last does not coincide with the final element is a
// framing error: err sticks until clear/reset and the partial frame is
// dropped by restarting at element (0,0).
module matrix_operand_loader #(
    parameter int M_SIZE     = 4,
    parameter int VAR_WIDTH  = 8,
    parameter int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic        err,
    output logic [15:0] mat_count,
    matrix_operand_loader_if.slave bus
);

    localparam int NUM_ELEM = M_SIZE * M_SIZE;
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    localparam logic [0:0] ST_FILL    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]            state_q,     state_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [DATA_WIDTH-1:0] mat_a_q,     mat_a_d;
    logic [DATA_WIDTH-1:0] mat_b_q,     mat_b_d;
    logic                  err_q,       err_d;
    logic [15:0]           mat_count_q, mat_count_d;

    logic in_ready_w;
    logic beat_w;
    logic handshake_w;
    logic idx_at_end_w;

    // acceptance and delivery qualifiers; in_ready is held low during reset
    always_comb begin
        in_ready_w   = reset & enable & (state_q == ST_FILL);
        beat_w       = bus.in_valid & in_ready_w;
        handshake_w  = (state_q == ST_PRESENT) & bus.out_ready;
        idx_at_end_w = (idx_q == LAST_IDX);
    end

    // frame sequencing: element index, state and sticky framing error
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (clear) begin
            state_d = ST_FILL;
            idx_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (beat_w) begin
                        if (idx_at_end_w && bus.in_last) begin
                            state_d = ST_PRESENT;
                            idx_d   = '0;
                        end else if (idx_at_end_w || bus.in_last) begin
                            err_d = 1'b1;
                            idx_d = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (handshake_w) begin
                        state_d = ST_FILL;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // element packing: element (0,0) lands in the most significant lane
    always_comb begin
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        if (clear) begin
            mat_a_d = '0;
            mat_b_d = '0;
        end else if (beat_w) begin
            for (int e = 0; e < NUM_ELEM; e++) begin
                if (idx_q == IDX_W'(e)) begin
                    mat_a_d[DATA_WIDTH-1-e*VAR_WIDTH -: VAR_WIDTH] = bus.in_a;
                    mat_b_d[DATA_WIDTH-1-e*VAR_WIDTH -: VAR_WIDTH] = bus.in_b;
                end
            end
        end
    end

    // delivered-pair counter, wraps naturally at 16 bits and survives clear
    always_comb begin
        mat_count_d = mat_count_q;
        if (!clear && handshake_w) begin
            mat_count_d = mat_count_q + 16'd1;
        end
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            err_q       <= 1'b0;
            mat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mat_a_q     <= mat_a_d;
            mat_b_q     <= mat_b_d;
            err_q       <= err_d;
            mat_count_q <= mat_count_d;
        end
    end

    // output drive
    always_comb begin
        bus.in_ready  = in_ready_w;
        bus.out_valid = (state_q == ST_PRESENT);
        bus.matrixA   = mat_a_q;
        bus.matrixB   = mat_b_q;
        err           = err_q;
        mat_count     = mat_count_q;
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: a frame-level model of the
// loader is compared on every falling edge, and literal packed values pin
// the model at the end of each scenario.
module tb_matrix_operand_loader;

    localparam int M_SIZE     = 4;
    localparam int VAR_WIDTH  = 8;
    localparam int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH;
    localparam int NUM        = M_SIZE * M_SIZE;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        err;
    logic [15:0] mat_count;

    int checks = 0;
    int errors = 0;

    matrix_operand_loader_if #(
        .M_SIZE(M_SIZE), .VAR_WIDTH(VAR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    matrix_operand_loader #(
        .M_SIZE(M_SIZE), .VAR_WIDTH(VAR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .enable    (enable),
        .err       (err),
        .mat_count (mat_count),
        .bus       (bus.slave)
    );

    always #5 clock = ~clock;

    // ---------------- frame-level model ----------------
    logic [7:0]  m_a [NUM];
    logic [7:0]  m_b [NUM];
    int          m_fill = 0;
    bit          m_present = 0;
    bit          m_err = 0;
    logic [15:0] m_count = 0;

    initial begin
        for (int i = 0; i < NUM; i++) begin
            m_a[i] = 8'h00;
            m_b[i] = 8'h00;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] pack(input logic [7:0] e [NUM]);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM; i++) r = (r << 8) | DATA_WIDTH'(e[i]);
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset || clear) begin
            for (int i = 0; i < NUM; i++) begin
                m_a[i] = 8'h00;
                m_b[i] = 8'h00;
            end
            m_fill    = 0;
            m_present = 0;
            m_err     = 0;
            if (!reset) m_count = 0;
        end else if (m_present) begin
            if (bus.out_ready) begin
                m_present = 0;
                m_count   = m_count + 16'd1;
            end
        end else if (bus.in_valid && enable) begin
            m_a[m_fill] = bus.in_a;
            m_b[m_fill] = bus.in_b;
            if (m_fill == NUM - 1 && bus.in_last) begin
                m_present = 1;
                m_fill    = 0;
            end else if (m_fill == NUM - 1 || bus.in_last) begin
                m_err  = 1;
                m_fill = 0;
            end else begin
                m_fill = m_fill + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [DATA_WIDTH-1:0] act,
                       input logic [DATA_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        chk("in_ready",  DATA_WIDTH'(bus.in_ready),
            DATA_WIDTH'(reset && enable && !m_present));
        chk("out_valid", DATA_WIDTH'(bus.out_valid), DATA_WIDTH'(m_present));
        chk("err",       DATA_WIDTH'(err),           DATA_WIDTH'(m_err));
        chk("mat_count", DATA_WIDTH'(mat_count),     DATA_WIDTH'(m_count));
        chk("matrixA",   bus.matrixA, pack(m_a));
        chk("matrixB",   bus.matrixB, pack(m_b));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        enable = 1'b1;
        step();
        step();
        chk("rst in_ready",  DATA_WIDTH'(bus.in_ready),  '0);
        chk("rst out_valid", DATA_WIDTH'(bus.out_valid), '0);
        chk("rst mat_count", DATA_WIDTH'(mat_count),     '0);
        chk("rst matrixA",   bus.matrixA, '0);
        reset = 1'b1;
        step();

        // back-to-back frame, out_ready already high
        bus.out_ready = 1'b1;
        for (int i = 0; i < NUM; i++) beat(8'(i), 8'(15 - i), i == NUM - 1);
        chk("s1 out_valid", DATA_WIDTH'(bus.out_valid), 1);
        chk("s1 matrixA", bus.matrixA, 128'h000102030405060708090a0b0c0d0e0f);
        chk("s1 matrixB", bus.matrixB, 128'h0f0e0d0c0b0a09080706050403020100);
        step();
        chk("s1 out_valid after hs", DATA_WIDTH'(bus.out_valid), 0);
        chk("s1 mat_count", DATA_WIDTH'(mat_count), 1);

        // backpressure for 5 cycles with a beat offered
        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM; i++) beat(8'(8'h20 + i), 8'(8'h30 + i), i == NUM - 1);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'hff;
        bus.in_b     = 8'hff;
        repeat (5) step();
        chk("s2 out_valid held", DATA_WIDTH'(bus.out_valid), 1);
        chk("s2 in_ready",       DATA_WIDTH'(bus.in_ready),  0);
        chk("s2 matrixA", bus.matrixA, 128'h202122232425262728292a2b2c2d2e2f);
        chk("s2 matrixB", bus.matrixB, 128'h303132333435363738393a3b3c3d3e3f);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("s2 out_valid after hs", DATA_WIDTH'(bus.out_valid), 0);
        chk("s2 mat_count", DATA_WIDTH'(mat_count), 2);

        // early in_last on beat 7, then a good frame
        for (int i = 0; i < 8; i++) beat(8'(8'h90 + i), 8'(8'ha0 + i), i == 7);
        chk("s3 err",       DATA_WIDTH'(err),           1);
        chk("s3 out_valid", DATA_WIDTH'(bus.out_valid), 0);
        for (int i = 0; i < NUM; i++) beat(8'(8'h40 + i), 8'(8'h50 + i), i == NUM - 1);
        chk("s3 out_valid", DATA_WIDTH'(bus.out_valid), 1);
        chk("s3 matrixA", bus.matrixA, 128'h404142434445464748494a4b4c4d4e4f);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("s3 err sticky", DATA_WIDTH'(err), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("s3 err cleared", DATA_WIDTH'(err), 0);
        chk("s3 mat_count", DATA_WIDTH'(mat_count), 3);

        // enable pause after beat 5 with in_valid held high
        for (int i = 0; i < 6; i++) beat(8'(8'h10 + i), 8'(8'h60 + i), 1'b0);
        enable       = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'hee;
        bus.in_b     = 8'hee;
        repeat (3) begin
            step();
            chk("s4 in_ready paused", DATA_WIDTH'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        enable       = 1'b1;
        for (int i = 6; i < NUM; i++) beat(8'(8'h10 + i), 8'(8'h60 + i), i == NUM - 1);
        chk("s4 matrixA", bus.matrixA, 128'h101112131415161718191a1b1c1d1e1f);
        chk("s4 matrixB", bus.matrixB, 128'h606162636465666768696a6b6c6d6e6f);

        // clear coincident with the output handshake
        clear         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        clear         = 1'b0;
        bus.out_ready = 1'b0;
        chk("s5 out_valid", DATA_WIDTH'(bus.out_valid), 0);
        chk("s5 mat_count", DATA_WIDTH'(mat_count), 3);
        chk("s5 matrixA",   bus.matrixA, '0);

        // asynchronous reset mid-cycle after beat 10
        for (int i = 0; i < 11; i++) beat(8'(8'hc0 + i), 8'(8'hd0 + i), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("s6 matrixA",   bus.matrixA, '0);
        chk("s6 matrixB",   bus.matrixB, '0);
        chk("s6 mat_count", DATA_WIDTH'(mat_count),     0);
        chk("s6 in_ready",  DATA_WIDTH'(bus.in_ready),  0);
        chk("s6 out_valid", DATA_WIDTH'(bus.out_valid), 0);
        step();
        reset = 1'b1;
        for (int i = 0; i < NUM; i++) beat(8'(8'h70 + i), 8'(8'h80 + i), i == NUM - 1);
        chk("s6 out_valid", DATA_WIDTH'(bus.out_valid), 1);
        chk("s6 frame A", bus.matrixA, 128'h707172737475767778797a7b7c7d7e7f);
        chk("s6 frame B", bus.matrixB, 128'h808182838485868788898a8b8c8d8e8f);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("s6 mat_count after hs", DATA_WIDTH'(mat_count), 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
